dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single data RAM between the pipeline MEM stage (cpu port) and a debug/loader port (dbg).
//  CPU has priority; dbg is served in idle MEM cycles or forcibly after STARVE_MAX blocked cycles.
//  On a forced dbg cycle the pipeline is frozen via cpu_stall. Sits between EX/MEM outputs and RAM.
// PARAMETERS
//  AW          9    RAM byte-address width (matches data RAM A port)
//  STARVE_MAX  4    blocked dbg cycles before forced grant; legal range 1..255
//  CNT_W       16   width of saturating cpu-stall statistics counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-low reset
//  cpu_e      in   1      MEM-stage access enable (E_MEM)
//  cpu_rw     in   1      1=store, 0=load
//  cpu_size   in   2      access size, RAM Size encoding
//  cpu_se     in   1      sign-extend on load
//  cpu_addr   in   AW     byte address (ALU_OUT_MEM[AW-1:0])
//  cpu_wdata  in   32     store data
//  cpu_rdata  out  32     load data (ram_do when cpu owns RAM, else 0)
//  cpu_stall  out  1      freeze IF/ID/EX/MEM this cycle
//  dbg_req    in   1      dbg request, level; held until dbg_ack
//  dbg_rw     in   1      1=store, 0=load
//  dbg_size   in   2      access size
//  dbg_addr   in   AW     byte address
//  dbg_wdata  in   32     store data
//  dbg_ack    out  1      one-cycle completion pulse
//  dbg_rdata  out  32     registered load data, valid with dbg_ack, held until next ack
//  ram_a/ram_di/ram_size/ram_rw/ram_e/ram_se  out  AW/32/2/1/1/1  RAM drive
//  ram_do     in   32     RAM read data (combinational)
//  stall_cnt  out  CNT_W  count of forced-stall cycles, saturating
// BEHAVIOUR
//  Reset (reset=0, async): state=ARB, starve=0, dbg_ack=0, dbg_rdata=0, stall_cnt=0; ram_e=0, cpu_stall=0.
//  States: ARB (grant decided combinationally), ACK (one cycle, dbg_ack=1, no dbg grant).
//  ARB grant rule, evaluated every cycle:
//   dbg_gnt = dbg_req & (~cpu_e | starve==STARVE_MAX); cpu_gnt = cpu_e & ~dbg_gnt.
//   cpu_gnt: RAM ports = cpu_* ; cpu_rdata=ram_do; zero added latency.
//   dbg_gnt: RAM ports = dbg_*, ram_se=0; cpu_stall=cpu_e; next state ACK.
//   Neither: ram_e=0, other RAM outputs 0.
//  Transition ARB->ACK on dbg_gnt: dbg_rdata<=ram_do (loads only; stores keep old value); starve<=0.
//  ACK->ARB unconditionally; dbg_ack=1 only in ACK. cpu retains RAM in ACK (cpu_gnt=cpu_e).
//  Dbg latency: grant cycle + 1 -> ack. Min dbg issue interval 2 cycles.
//  starve: in ARB, +1 per cycle with dbg_req & ~dbg_gnt; saturates at STARVE_MAX; cleared on grant
//   or when dbg_req=0 in ARB. Holds in ACK.
//  stall_cnt: +1 per cycle with cpu_stall=1; saturates at 2^CNT_W-1; never wraps.
//  Boundaries:
//   dbg_req dropped before grant -> no access, starve cleared. Dropped during ACK -> ack still pulses.
//   dbg_req still high in ACK -> new request, eligible from next ARB cycle.
//   Forced grant with cpu_e=1 -> exactly one stall cycle; cpu access replays next cycle unchanged.
//   Same-address cpu/dbg in consecutive cycles -> strict grant order; later write wins.
//   Reset mid-ACK -> dbg_ack drops immediately; request lost; dbg must re-request.
//  cpu_rdata, cpu_stall, ram_* are combinational; dbg_ack, dbg_rdata, stall_cnt are registered.
// STRUCTURE
//  Package dmem_arb_pkg: state enum {ARB, ACK}; RW_STORE=1'b1 / RW_LOAD=1'b0; default AW.
//  Sub-module arb_starve_ctr: saturating counter (inc, clr, sat flag) used for starve and stall_cnt.
//  Top: 2-state FSM, grant logic, RAM output mux, dbg_rdata register.
// TESTING
//  1 cpu_e=0, dbg load @0x010 (RAM=0xDEADBEEF) -> ram_a=0x010 same cycle; next cycle dbg_ack=1,
//    dbg_rdata=0xDEADBEEF; cpu_stall never 1.
//  2 cpu_e=1 every cycle, dbg_req held, STARVE_MAX=4 -> grant on 5th cycle, cpu_stall=1 that cycle only,
//    stall_cnt=1; cpu sees one extra cycle.
//  3 dbg_req held through ACK, cpu idle -> grants at cycles t and t+2, acks at t+1 and t+3.
//  4 cpu store 0x11 @0x20 cycle n, dbg store 0x22 @0x20 cycle n+1, dbg load @0x20 -> dbg_rdata=0x22.
//  5 reset=0 during ACK -> dbg_ack=0, stall_cnt=0 without clock edge; after release state=ARB.
//  6 force stall_cnt=0xFFFE, two forced stalls -> stall_cnt=0xFFFF, stays 0xFFFF.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-RAM arbiter between the MEM stage and the debug port.
package dmem_arb_pkg;

  typedef enum logic {
    ARB = 1'b0,
    ACK = 1'b1
  } arb_state_e;

  localparam logic RW_STORE = 1'b1;
  localparam logic RW_LOAD  = 1'b0;

  localparam int DEF_AW   = 9;
  localparam int STARVE_W = 8;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating up-counter with clear priority; used both for dbg starvation and stall statistics.
module arb_starve_ctr #(
  parameter int          W   = 8,
  parameter logic [W-1:0] MAX = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         sat
);

  assign sat = (count == MAX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the data RAM between the pipeline MEM stage (priority) and a debug/loader port,
// forcing a one-cycle pipeline stall when the debug port has been starved too long.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_e,
  input  logic             cpu_rw,
  input  logic [1:0]       cpu_size,
  input  logic             cpu_se,
  input  logic [AW-1:0]    cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic [31:0]      cpu_rdata,
  output logic             cpu_stall,
  input  logic             dbg_req,
  input  logic             dbg_rw,
  input  logic [1:0]       dbg_size,
  input  logic [AW-1:0]    dbg_addr,
  input  logic [31:0]      dbg_wdata,
  output logic             dbg_ack,
  output logic [31:0]      dbg_rdata,
  output logic [AW-1:0]    ram_a,
  output logic [31:0]      ram_di,
  output logic [1:0]       ram_size,
  output logic             ram_rw,
  output logic             ram_e,
  output logic             ram_se,
  input  logic [31:0]      ram_do,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic                dbg_gnt, cpu_gnt;
  logic                starve_inc, starve_clr, starve_full;
  logic [STARVE_W-1:0] starve;
  logic                stall_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARB;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (dbg_gnt) state_d = ACK;
      ACK:     state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Grants are suppressed while reset is asserted so the RAM is never driven during reset.
  always_comb begin
    dbg_gnt = reset && (state_q == ARB) && dbg_req && (!cpu_e || starve_full);
    cpu_gnt = reset && cpu_e && !dbg_gnt;
  end

  always_comb begin
    ram_a     = '0;
    ram_di    = '0;
    ram_size  = '0;
    ram_rw    = 1'b0;
    ram_e     = 1'b0;
    ram_se    = 1'b0;
    cpu_rdata = '0;
    cpu_stall = 1'b0;
    if (dbg_gnt) begin
      ram_a     = dbg_addr;
      ram_di    = dbg_wdata;
      ram_size  = dbg_size;
      ram_rw    = dbg_rw;
      ram_e     = 1'b1;
      cpu_stall = cpu_e;
    end else if (cpu_gnt) begin
      ram_a     = cpu_addr;
      ram_di    = cpu_wdata;
      ram_size  = cpu_size;
      ram_rw    = cpu_rw;
      ram_e     = 1'b1;
      ram_se    = cpu_se;
      cpu_rdata = ram_do;
    end
  end

  assign dbg_ack = (state_q == ACK);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_rdata <= '0;
    end else if (dbg_gnt && (dbg_rw == RW_LOAD)) begin
      dbg_rdata <= ram_do;
    end
  end

  // Starvation only advances in ARB; it holds through ACK so a re-request keeps its history.
  assign starve_inc = (state_q == ARB) && dbg_req && !dbg_gnt && (starve != STARVE_LIM);
  assign starve_clr = (state_q == ARB) && (dbg_gnt || !dbg_req);

  arb_starve_ctr #(
    .W   (STARVE_W),
    .MAX (STARVE_LIM)
  ) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .count (starve),
    .sat   (starve_full)
  );

  arb_starve_ctr #(
    .W   (CNT_W),
    .MAX ({CNT_W{1'b1}})
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (cpu_stall && !stall_full),
    .clr   (1'b0),
    .count (stall_cnt),
    .sat   (stall_full)
  );

endmodule
